// File: rtl/chdr_resp_arbiter.sv
// Packet-atomic round-robin merge of the error (port 0) and ack (port 1) CHDR response
// streams with per-window throttling of error packets. Macro CHDR_RESP_ARBITER_DROP_COUNT_EN enables drop_count.
module chdr_resp_arbiter #(
    parameter logic [15:0] WINDOW_CYCLES = 16'd1000,
    parameter logic [3:0]  MAX_ERR       = 4'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [63:0] i0_tdata,
    input  logic        i0_tlast,
    input  logic        i0_tvalid,
    output logic        i0_tready,
    input  logic [63:0] i1_tdata,
    input  logic        i1_tlast,
    input  logic        i1_tvalid,
    output logic        i1_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [31:0] drop_count,
    output logic [1:0]  dbg_state_o,
    output logic [3:0]  dbg_err_cnt_o
);

    // Handshake: every stream is AXI-Stream style; a beat transfers on a cycle where
    // tvalid && tready, tvalid stays high until that transfer, and tlast marks a packet's final beat.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2,
        DROP0 = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] win_cnt_q, win_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic        win_wrap;
    logic        throttled;
    logic        pass0_entry;

    assign throttled   = (err_cnt_q >= MAX_ERR);
    assign win_wrap    = (win_cnt_q == (WINDOW_CYCLES - 16'd1));
    assign pass0_entry = (state_q == IDLE) && (state_d == PASS0);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        o_tdata      = '0;
        o_tlast      = 1'b0;
        o_tvalid     = 1'b0;
        i0_tready    = 1'b0;
        i1_tready    = 1'b0;
        case (state_q)
            IDLE: begin
                // Port 0 wins when alone, or on a tie when port 1 was granted last.
                if (i0_tvalid && (!i1_tvalid || last_grant_q)) begin
                    state_d = throttled ? DROP0 : PASS0;
                end else if (i1_tvalid) begin
                    state_d = PASS1;
                end
            end
            PASS0: begin
                o_tdata   = i0_tdata;
                o_tlast   = i0_tlast;
                o_tvalid  = i0_tvalid;
                i0_tready = o_tready;
                if (i0_tvalid && o_tready && i0_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            PASS1: begin
                o_tdata   = i1_tdata;
                o_tlast   = i1_tlast;
                o_tvalid  = i1_tvalid;
                i1_tready = o_tready;
                if (i1_tvalid && o_tready && i1_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            DROP0: begin
                i0_tready = 1'b1;
                if (i0_tvalid && i0_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        win_cnt_d = win_wrap ? 16'd0 : (win_cnt_q + 16'd1);
        err_cnt_d = err_cnt_q;
        // A packet admitted on the wrap cycle is the first one of the new window.
        if (win_wrap) begin
            err_cnt_d = pass0_entry ? 4'd1 : 4'd0;
        end else if (pass0_entry && (err_cnt_q != 4'hF)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else if (clear) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            win_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            win_cnt_q    <= win_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef CHDR_RESP_ARBITER_DROP_COUNT_EN
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        drop_done;

    assign drop_done = (state_q == DROP0) && i0_tvalid && i0_tlast;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_done && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else if (clear) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 32'd0;
`endif

    assign dbg_state_o   = state_q;
    assign dbg_err_cnt_o = err_cnt_q;

endmodule
